lcd_word_sequencer: RTL and testbench

LCD_WORD_SEQUENCER -- requirements
Module: lcd_word_sequencer

---
 rtl/lcd_word_sequencer.sv | 250 +++++++++++++++++++++++++
 tb/tb_lcd_word_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_word_sequencer
//  Purpose  : Drives an HD44780-style character LCD in 8-bit mode. After a
//             power-up wait it sends the init commands, then for each gesture
//             strobe it looks up a 6-character word and writes it to line 1.
//             Strobes that arrive while busy are held (latest wins) and are
//             serviced without returning to IDLE.
//  Ports    : clk           - system clock, rising edge
//             rst_n         - asynchronous active-low reset
//             gesture_valid - one-cycle strobe qualifying gesture_code
//             gesture_code  - gesture index
//             word_sel      - code driven to the external word lookup
//             word_chars    - lookup result {c5..c0}, ASCII
//             lcd_rs        - 0 = command, 1 = data
//             lcd_e         - LCD enable strobe
//             lcd_data      - LCD data bus
//             busy          - high whenever not IDLE
//             done          - one-cycle pulse when a word write completes
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_word_sequencer #(
   parameter int POWERUP_CYCLES = 750000,
   parameter int E_CYCLES       = 25,
   parameter int GAP_CYCLES     = 2500,
   parameter int CLEAR_CYCLES   = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        gesture_valid,
   input  logic [3:0]  gesture_code,
   output logic [3:0]  word_sel,
   input  logic [47:0] word_chars,
   output logic        lcd_rs,
   output logic        lcd_e,
   output logic [7:0]  lcd_data,
   output logic        busy,
   output logic        done
);

   localparam int c_MAX_A = (POWERUP_CYCLES > CLEAR_CYCLES) ? POWERUP_CYCLES : CLEAR_CYCLES;
   localparam int c_MAX_B = (GAP_CYCLES > E_CYCLES) ? GAP_CYCLES : E_CYCLES;
   localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
   localparam int c_CW    = $clog2(c_MAX + 1);

   localparam logic [c_CW-1:0] c_PWR_LAST   = c_CW'(POWERUP_CYCLES - 1);
   localparam logic [c_CW-1:0] c_E_LAST     = c_CW'(E_CYCLES - 1);
   localparam logic [c_CW-1:0] c_GAP_LAST   = c_CW'(GAP_CYCLES - 1);
   localparam logic [c_CW-1:0] c_CLEAR_LAST = c_CW'(CLEAR_CYCLES - 1);

   typedef enum logic [2:0] {
      S_PWRUP = 3'd0,
      S_INIT  = 3'd1,
      S_IDLE  = 3'd2,
      S_FETCH = 3'd3,
      S_ADDR  = 3'd4,
      S_CHARS = 3'd5,
      S_FIN   = 3'd6
   } state_t;

   // Phases of a single byte write: setup (e low), strobe (e high), hold (e low)
   typedef enum logic [1:0] {
      PH_SETUP = 2'd0,
      PH_EHI   = 2'd1,
      PH_HOLD  = 2'd2
   } phase_t;

   state_t            state_q;
   phase_t            phase_q;
   logic [c_CW-1:0]   cnt_q;
   logic [2:0]        idx_q;
   logic [47:0]       chars_q;
   logic [3:0]        word_sel_q;
   logic              pend_q;
   logic [3:0]        pend_code_q;
   logic              lcd_e_q;
   logic              lcd_rs_q;
   logic [7:0]        lcd_data_q;
   logic              done_q;

   logic [c_CW-1:0]   w_hold_last;
   logic              w_byte_done;
   logic              w_req_valid;
   logic [3:0]        w_req_code;

   function automatic logic [7:0] init_cmd(input logic [2:0] i);
      case (i)
         3'd0:    init_cmd = 8'h38;
         3'd1:    init_cmd = 8'h0C;
         3'd2:    init_cmd = 8'h06;
         default: init_cmd = 8'h01;
      endcase
   endfunction

   function automatic logic [7:0] char_at(input logic [47:0] b, input logic [2:0] i);
      case (i)
         3'd0:    char_at = b[47:40];
         3'd1:    char_at = b[39:32];
         3'd2:    char_at = b[31:24];
         3'd3:    char_at = b[23:16];
         3'd4:    char_at = b[15:8];
         default: char_at = b[7:0];
      endcase
   endfunction

   // Only the clear command (last init byte) gets the long hold
   assign w_hold_last = (state_q == S_INIT && idx_q == 3'd3) ? c_CLEAR_LAST : c_GAP_LAST;
   assign w_byte_done = (phase_q == PH_HOLD) && (cnt_q == w_hold_last);

   // A strobe in the very cycle a request is serviced is newer than any
   // pending code, so it takes priority and is consumed directly.
   assign w_req_valid = gesture_valid | pend_q;
   assign w_req_code  = gesture_valid ? gesture_code : pend_code_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_PWRUP;
         phase_q     <= PH_SETUP;
         cnt_q       <= '0;
         idx_q       <= 3'd0;
         chars_q     <= '0;
         word_sel_q  <= 4'd0;
         pend_q      <= 1'b0;
         pend_code_q <= 4'd0;
         lcd_e_q     <= 1'b0;
         lcd_rs_q    <= 1'b0;
         lcd_data_q  <= 8'h00;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;

         // Capture strobes while busy; servicing branches below clear this
         if (gesture_valid && state_q != S_IDLE) begin
            pend_q      <= 1'b1;
            pend_code_q <= gesture_code;
         end

         // Shared byte-write timing; completion is handled per state
         if ((state_q == S_INIT || state_q == S_ADDR || state_q == S_CHARS) && !w_byte_done) begin
            case (phase_q)
               PH_SETUP: begin
                  lcd_e_q <= 1'b1;
                  phase_q <= PH_EHI;
                  cnt_q   <= '0;
               end
               PH_EHI: begin
                  if (cnt_q == c_E_LAST) begin
                     lcd_e_q <= 1'b0;
                     phase_q <= PH_HOLD;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               default: cnt_q <= cnt_q + 1'b1;
            endcase
         end

         case (state_q)
            S_PWRUP: begin
               if (cnt_q == c_PWR_LAST) begin
                  state_q    <= S_INIT;
                  idx_q      <= 3'd0;
                  phase_q    <= PH_SETUP;
                  cnt_q      <= '0;
                  lcd_rs_q   <= 1'b0;
                  lcd_data_q <= init_cmd(3'd0);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_INIT: begin
               if (w_byte_done) begin
                  cnt_q <= '0;
                  if (idx_q == 3'd3) begin
                     if (w_req_valid) begin
                        word_sel_q <= w_req_code;
                        pend_q     <= 1'b0;
                        state_q    <= S_FETCH;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     idx_q      <= idx_q + 3'd1;
                     phase_q    <= PH_SETUP;
                     lcd_data_q <= init_cmd(idx_q + 3'd1);
                  end
               end
            end
            S_IDLE: begin
               if (w_req_valid) begin
                  word_sel_q <= w_req_code;
                  pend_q     <= 1'b0;
                  state_q    <= S_FETCH;
               end
            end
            S_FETCH: begin
               chars_q    <= word_chars;
               state_q    <= S_ADDR;
               phase_q    <= PH_SETUP;
               cnt_q      <= '0;
               lcd_rs_q   <= 1'b0;
               lcd_data_q <= 8'h80;
            end
            S_ADDR: begin
               if (w_byte_done) begin
                  state_q    <= S_CHARS;
                  idx_q      <= 3'd0;
                  phase_q    <= PH_SETUP;
                  cnt_q      <= '0;
                  lcd_rs_q   <= 1'b1;
                  lcd_data_q <= char_at(chars_q, 3'd0);
               end
            end
            S_CHARS: begin
               if (w_byte_done) begin
                  cnt_q <= '0;
                  if (idx_q == 3'd5) begin
                     state_q <= S_FIN;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q      <= idx_q + 3'd1;
                     phase_q    <= PH_SETUP;
                     lcd_data_q <= char_at(chars_q, idx_q + 3'd1);
                  end
               end
            end
            S_FIN: begin
               if (w_req_valid) begin
                  word_sel_q <= w_req_code;
                  pend_q     <= 1'b0;
                  state_q    <= S_FETCH;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_PWRUP;
         endcase
      end
   end

   assign word_sel = word_sel_q;
   assign lcd_e    = lcd_e_q;
   assign lcd_rs   = lcd_rs_q;
   assign lcd_data = lcd_data_q;
   assign done     = done_q;
   assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lcd_word_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_word_sequencer
//  Purpose  : Self-checking bench for lcd_word_sequencer. Expected LCD bytes
//             are queued when stimulus is applied and compared as each
//             lcd_e pulse appears on the bus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_word_sequencer;

   localparam int P = 8;
   localparam int E = 2;
   localparam int G = 3;
   localparam int C = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gesture_valid = 1'b0;
   logic [3:0]  gesture_code = 4'd0;
   logic [3:0]  word_sel;
   logic [47:0] word_chars;
   logic        lcd_rs;
   logic        lcd_e;
   logic [7:0]  lcd_data;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   lcd_word_sequencer #(
      .POWERUP_CYCLES (P),
      .E_CYCLES       (E),
      .GAP_CYCLES     (G),
      .CLEAR_CYCLES   (C)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .gesture_valid (gesture_valid),
      .gesture_code  (gesture_code),
      .word_sel      (word_sel),
      .word_chars    (word_chars),
      .lcd_rs        (lcd_rs),
      .lcd_e         (lcd_e),
      .lcd_data      (lcd_data),
      .busy          (busy),
      .done          (done)
   );

   // Gesture-to-word lookup model
   function automatic logic [47:0] lut(input logic [3:0] c);
      case (c)
         4'd0:    lut = "      ";
         4'd1:    lut = "   YES";
         4'd4:    lut = " WATER";
         4'd10:   lut = "  FOOD";
         4'd11:   lut = "THIRST";
         4'd15:   lut = "THANKS";
         default: lut = "??????";
      endcase
   endfunction

   always_comb word_chars = lut(word_sel);

   logic [8:0] sb[$];
   int vectors  = 0;
   int errors   = 0;
   int done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic push_byte(input logic rs, input logic [7:0] d);
      sb.push_back({rs, d});
   endtask

   task automatic push_init();
      push_byte(1'b0, 8'h38);
      push_byte(1'b0, 8'h0C);
      push_byte(1'b0, 8'h06);
      push_byte(1'b0, 8'h01);
   endtask

   task automatic push_word(input logic [3:0] code);
      logic [47:0] w;
      w = lut(code);
      push_byte(1'b0, 8'h80);
      for (int i = 0; i < 6; i++) push_byte(1'b1, w[47-8*i -: 8]);
   endtask

   task automatic strobe(input logic [3:0] code);
      gesture_code  = code;
      gesture_valid = 1'b1;
      @(negedge clk);
      gesture_valid = 1'b0;
   endtask

   task automatic wait_busy_low(input string tag, input int bound);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
   endtask

   // Bus monitor: compares each strobed byte against the scoreboard and
   // checks strobe width and bus stability around the strobe.
   logic       prev_e = 1'b0;
   logic [8:0] prev_bus = 9'd0;
   logic [8:0] pulse_bus = 9'd0;
   int         hi_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_e   = 1'b0;
         hi_cnt   = 0;
         prev_bus = {lcd_rs, lcd_data};
      end else begin
         if (done === 1'b1) done_cnt++;
         if (lcd_e === 1'b1 && !prev_e) begin
            chk("setup_stable", 32'({lcd_rs, lcd_data}), 32'(prev_bus));
            vectors++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL sb_underflow: observed=%0h expected=none", {lcd_rs, lcd_data});
            end
            if (sb.size() != 0) chk("lcd_byte", 32'({lcd_rs, lcd_data}), 32'(sb.pop_front()));
            pulse_bus = {lcd_rs, lcd_data};
            hi_cnt    = 1;
         end else if (lcd_e === 1'b1) begin
            hi_cnt++;
         end else if (prev_e) begin
            chk("e_width", 32'(hi_cnt), 32'(E));
            chk("hold_stable", 32'({lcd_rs, lcd_data}), 32'(pulse_bus));
         end
         prev_e   = (lcd_e === 1'b1);
         prev_bus = {lcd_rs, lcd_data};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int k;
      int dn;
      int idle_seen;
      int d0;
      logic pe;

      // ---- reset state ----
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_lcd_e",    32'(lcd_e),    32'd0);
      chk("rst_lcd_rs",   32'(lcd_rs),   32'd0);
      chk("rst_lcd_data", 32'(lcd_data), 32'h00);
      chk("rst_word_sel", 32'(word_sel), 32'd0);
      chk("rst_busy",     32'(busy),     32'd1);
      chk("rst_done",     32'(done),     32'd0);

      // ---- power-up and init ----
      push_init();
      rst_n = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (lcd_e !== 1'b1 && n < 100);
      chk("pwrup_to_first_e", 32'(n), 32'(P + 1));
      while (busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
      chk("init_length", 32'(n), 32'(P + 3*(1+E+G) + (1+E+C)));
      chk("sb_empty_init", 32'(sb.size()), 32'd0);

      // ---- single word, latency ----
      push_word(4'd1);
      gesture_code  = 4'd1;
      gesture_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            gesture_valid = 1'b0;
            chk("word_sel_1", 32'(word_sel), 32'd1);
         end
      end while (done !== 1'b1 && n < 200);
      chk("latency_yes", 32'(n), 32'(2 + 7*(1+E+G)));
      @(negedge clk);
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("idle_after_fin", 32'(busy), 32'd0);
      chk("sb_empty_yes", 32'(sb.size()), 32'd0);

      // ---- back-to-back, latest pending wins ----
      d0 = done_cnt;
      push_word(4'd4);
      push_word(4'd15);
      strobe(4'd4);
      n = 0;
      while (!(lcd_e === 1'b1 && lcd_rs === 1'b1) && n < 100) begin @(negedge clk); n++; end
      chk("reached_chars", 32'(lcd_rs), 32'd1);
      strobe(4'd10);
      repeat (3) @(negedge clk);
      strobe(4'd15);
      dn = 0; idle_seen = 0; n = 0;
      while (dn < 2 && n < 300) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) dn++;
         if (busy === 1'b0) idle_seen++;
      end
      chk("two_done", 32'(dn), 32'd2);
      chk("no_idle_between", 32'(idle_seen), 32'd0);
      wait_busy_low("idle_after_pair", 20);
      repeat (3) @(negedge clk);
      chk("done_count_pair", 32'(done_cnt - d0), 32'd2);
      chk("sb_empty_pair", 32'(sb.size()), 32'd0);

      // ---- reset mid-write during the 3rd character ----
      push_word(4'd1);
      strobe(4'd1);
      k = 0; n = 0; pe = 1'b0;
      while (k < 3 && n < 200) begin
         @(negedge clk);
         n++;
         if (lcd_e === 1'b1 && lcd_rs === 1'b1 && !pe) k++;
         pe = (lcd_e === 1'b1);
      end
      chk("third_char_high", 32'(lcd_e), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_lcd_e",    32'(lcd_e),    32'd0);
      chk("midrst_busy",     32'(busy),     32'd1);
      chk("midrst_word_sel", 32'(word_sel), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);

      // ---- strobe during init is serviced without IDLE ----
      push_init();
      push_word(4'd11);
      rst_n = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (lcd_e !== 1'b1 && n < 100);
      chk("reinit_first_e", 32'(n), 32'(P + 1));
      strobe(4'd11);
      idle_seen = 0; n = 0;
      while (done !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
         if (busy === 1'b0) idle_seen++;
      end
      chk("thirst_done", 32'(done), 32'd1);
      chk("thirst_no_idle", 32'(idle_seen), 32'd0);
      chk("thirst_word_sel", 32'(word_sel), 32'd11);
      wait_busy_low("idle_after_thirst", 20);
      chk("sb_empty_thirst", 32'(sb.size()), 32'd0);

      // ---- strobe exactly in the FIN cycle ----
      push_word(4'd1);
      push_word(4'd0);
      strobe(4'd1);
      n = 0;
      while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("fin_first_done", 32'(done), 32'd1);
      strobe(4'd0);
      chk("fin_strobe_busy", 32'(busy), 32'd1);
      chk("fin_strobe_sel", 32'(word_sel), 32'd0);
      n = 0;
      while (done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("fin_second_done", 32'(done), 32'd1);
      wait_busy_low("idle_after_blank", 20);
      chk("sb_empty_blank", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
